lsu: RTL and testbench

//  Load/store unit directly downstream of the execute stage. Latches one

---
 rtl/lsu.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: load/store unit that runs one request at a time as an AXI4-Lite master.
// Define LSU_TIMEOUT_EN to abort bus accesses that exceed TIMEOUT_CYCLES cycles.
module lsu
`ifdef LSU_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 256)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        is_store,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        respValid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_bus,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata_bus,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;
  state_t state_reg, state_next;

  logic [31:0] addr_reg, wdata_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic [2:0]  size_reg;
  logic        err_reg, err_next;
  logic        aw_done_reg, w_done_reg;
  logic        accept, aw_hs, w_hs;
  logic        illegal_size, misaligned, timeout_hit;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // BU/HU are load-only encodings, so a store using them is rejected like a bad size.
  assign illegal_size = (size == 3'b011) || (size[2] && size[1]) || (is_store && size[2]);
  assign misaligned   = illegal_size
                     || ((size[1:0] == 2'b01) && addr[0])
                     || ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_bus[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? rdata_bus[31:16] : rdata_bus[15:0];

  always_comb begin
    load_ext = rdata_bus;
    case (size_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = rdata_bus;
    endcase
  end

  always_comb begin
    wdata_bus = wdata_reg;
    wstrb     = 4'b1111;
    case (size_reg[1:0])
      2'b00: begin
        wdata_bus = {4{wdata_reg[7:0]}};
        wstrb     = 4'b0001 << addr_reg[1:0];
      end
      2'b01: begin
        wdata_bus = {2{wdata_reg[15:0]}};
        wstrb     = 4'b0011 << addr_reg[1:0];
      end
      default: ;
    endcase
  end

  assign araddr    = {addr_reg[31:2], 2'b00};
  assign awaddr    = {addr_reg[31:2], 2'b00};
  assign rdata     = (state_reg == DONE) ? rdata_reg : 32'h0;
  assign resp_err  = (state_reg == DONE) && err_reg;

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    rdata_next = rdata_reg;
    accept     = 1'b0;
    reqReady   = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    respValid  = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held low while reset is asserted so nothing looks acceptable during reset.
        reqReady = reset;
        if (reqValid) begin
          accept     = 1'b1;
          err_next   = misaligned;
          rdata_next = 32'h0;
          if (misaligned)    state_next = DONE;
          else if (is_store) state_next = WR;
          else               state_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          err_next   = (rresp != 2'b00);
          rdata_next = (rresp != 2'b00) ? 32'h0 : load_ext;
          state_next = DONE;
        end
      end
      WR: begin
        awvalid = !aw_done_reg;
        wvalid  = !w_done_reg;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_next   = (bresp != 2'b00);
          state_next = DONE;
        end
      end
      DONE: begin
        respValid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // An abort withdraws every bus valid/ready in the same cycle so no late handshake slips in.
    if (timeout_hit) begin
      arvalid    = 1'b0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      err_next   = 1'b1;
      rdata_next = 32'h0;
      state_next = DONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      size_reg     <= 3'b000;
      err_reg      <= 1'b0;
      rdata_reg    <= 32'h0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      if (accept) begin
        addr_reg     <= addr;
        wdata_reg    <= wdata;
        size_reg     <= size;
        aw_done_reg  <= 1'b0;
        w_done_reg   <= 1'b0;
      end else begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_reg;
  logic          bus_busy;

  assign bus_busy    = (state_reg == RD_ADDR) || (state_reg == RD_DATA)
                    || (state_reg == WR)      || (state_reg == WR_RESP);
  assign timeout_hit = bus_busy && (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        tmo_cnt_reg <= '0;
    else if (accept)                   tmo_cnt_reg <= '0;
    else if (bus_busy && !timeout_hit) tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, alignment errors, bus errors, reset abort.
module tb_lsu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0, is_store = 1'b0;
  logic [2:0]  size = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        reqReady, respValid, resp_err;
  logic [31:0] rdata;
  logic [31:0] araddr, awaddr, wdata_bus;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata_bus = 32'h0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int bus_cnt = 0;
  int cyc;
  int snap;

  always #5 clock = ~clock;

  lsu dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .is_store(is_store), .size(size),
    .addr(addr), .wdata(wdata),
    .respValid(respValid), .rdata(rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata_bus(rdata_bus), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_bus(wdata_bus), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always @(posedge clock) begin
    if (respValid) resp_cnt++;
    if (arvalid || awvalid || wvalid) bus_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    reqValid = 1'b1; is_store = st; size = sz; addr = a; wdata = wd;
    @(negedge clock);
    reqValid = 1'b0;
  endtask

  task automatic wait_resp(input int limit, output int n);
    n = 1;
    while (respValid !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("resp_seen", 32'(respValid), 32'd1);
  endtask

  task automatic post(input string tag);
    @(negedge clock);
    check({tag, "_pulse_end"}, 32'(respValid), 32'd0);
    check({tag, "_ready_back"}, 32'(reqReady), 32'd1);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] word, input logic [1:0] rr,
                          input logic [31:0] exp_data, input logic exp_err);
    int n;
    rdata_bus = word; rresp = rr; arready = 1'b1; rvalid = 1'b1;
    issue(1'b0, sz, a, 32'h0);
    wait_resp(20, n);
    $display("load %s addr=%h word=%h -> rdata=%h err=%0b cycles=%0d", tag, a, word, rdata, resp_err, n);
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    post(tag);
  endtask

  task automatic store_chk(input string tag, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] br, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wbus, input logic exp_err);
    int n;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = br;
    issue(1'b1, sz, a, wd);
    check({tag, "_awvalid"}, 32'(awvalid), 32'd1);
    check({tag, "_wvalid"}, 32'(wvalid), 32'd1);
    check({tag, "_awaddr"}, awaddr, {a[31:2], 2'b00});
    check({tag, "_wstrb"}, 32'(wstrb), 32'(exp_strb));
    check({tag, "_wbus"}, wdata_bus, exp_wbus);
    wait_resp(20, n);
    $display("store %s addr=%h wdata=%h -> strb=%b err=%0b cycles=%0d", tag, a, wd, exp_strb, resp_err, n);
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_rdata"}, rdata, 32'h0);
    post(tag);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_reqReady", 32'(reqReady), 32'd0);
    check("rst_respValid", 32'(respValid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_reqReady", 32'(reqReady), 32'd1);
    $display("reset released: reqReady=%0b", reqReady);

    // LW with address-channel visibility
    rdata_bus = 32'hDEADBEEF; rresp = 2'b00; arready = 1'b1; rvalid = 1'b1;
    issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    check("lw_arvalid", 32'(arvalid), 32'd1);
    check("lw_araddr", araddr, 32'h8000_0004);
    wait_resp(20, cyc);
    $display("load lw addr=80000004 -> rdata=%h err=%0b cycles=%0d", rdata, resp_err, cyc);
    check("lw_lat", 32'(cyc), 32'd3);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_err", 32'(resp_err), 32'd0);
    post("lw");

    // Sub-word loads (back-to-back: each issued the cycle after the previous pulse)
    load_chk("lb",  3'b000, 32'h8000_0003, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 1'b0);
    load_chk("lbu", 3'b100, 32'h8000_0003, 32'h80FF_FFFF, 2'b00, 32'h0000_0080, 1'b0);
    load_chk("lh",  3'b001, 32'h8000_0002, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0);
    load_chk("lhu", 3'b101, 32'h8000_0000, 32'h8001_1234, 2'b00, 32'h0000_1234, 1'b0);
    load_chk("lb1", 3'b000, 32'h0000_0011, 32'h1122_7F44, 2'b00, 32'h0000_007F, 1'b0);
    load_chk("lw_slverr", 3'b010, 32'h8000_0008, 32'h1234_5678, 2'b10, 32'h0, 1'b1);
    rresp = 2'b00;

    // Stores
    store_chk("sh", 3'b001, 32'h8000_0002, 32'h0000_1234, 2'b00, 4'b1100, 32'h1234_1234, 1'b0);
    store_chk("sb", 3'b000, 32'h0000_0101, 32'h0000_00AB, 2'b00, 4'b0010, 32'hABAB_ABAB, 1'b0);
    store_chk("sw", 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 2'b00, 4'b1111, 32'hCAFE_F00D, 1'b0);
    store_chk("sw_decerr", 3'b010, 32'h0000_0300, 32'h0000_0001, 2'b11, 4'b1111, 32'h0000_0001, 1'b1);
    bresp = 2'b00;

    // Misaligned / illegal requests: no bus traffic, error response
    snap = bus_cnt;
    issue(1'b0, 3'b010, 32'h8000_0001, 32'h0);
    wait_resp(5, cyc);
    $display("load lw_mis addr=80000001 -> err=%0b rdata=%h", resp_err, rdata);
    check("mis_lw_err", 32'(resp_err), 32'd1);
    check("mis_lw_rdata", rdata, 32'h0);
    post("mis_lw");
    issue(1'b1, 3'b001, 32'h0000_0043, 32'h5555_5555);
    wait_resp(5, cyc);
    $display("store sh_mis addr=00000043 -> err=%0b", resp_err);
    check("mis_sh_err", 32'(resp_err), 32'd1);
    post("mis_sh");
    issue(1'b1, 3'b100, 32'h0000_0040, 32'h0);
    wait_resp(5, cyc);
    $display("store sbu_illegal -> err=%0b", resp_err);
    check("ill_sbu_err", 32'(resp_err), 32'd1);
    post("ill_sbu");
    check("mis_no_bus", 32'(bus_cnt), 32'(snap));

    // Store where AW is accepted three cycles after W
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    snap = resp_cnt;
    issue(1'b1, 3'b010, 32'h0000_0010, 32'h0000_0055);
    check("dly_both_valid", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clock);
    check("dly_wvalid_drop", 32'(wvalid), 32'd0);
    check("dly_awvalid_hold", 32'(awvalid), 32'd1);
    check("dly_awaddr_hold", awaddr, 32'h0000_0010);
    @(negedge clock);
    check("dly_awvalid_hold2", 32'(awvalid), 32'd1);
    @(negedge clock);
    awready = 1'b1;
    wait_resp(20, cyc);
    $display("store delayed_aw -> err=%0b", resp_err);
    check("dly_err", 32'(resp_err), 32'd0);
    post("dly");
    check("dly_one_resp", 32'(resp_cnt - snap), 32'd1);

    // Reset asserted while waiting in RD_DATA
    arready = 1'b1; rvalid = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    @(negedge clock);
    check("rstmid_rready", 32'(rready), 32'd1);
    snap = resp_cnt;
    #2 reset = 1'b0;
    #1;
    check("rstmid_rready0", 32'(rready), 32'd0);
    check("rstmid_arvalid0", 32'(arvalid), 32'd0);
    check("rstmid_respValid0", 32'(respValid), 32'd0);
    check("rstmid_reqReady0", 32'(reqReady), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rvalid = 1'b1;
    repeat (4) @(negedge clock);
    $display("reset mid-read: responses after abort=%0d", resp_cnt - snap);
    check("rstmid_no_resp", 32'(resp_cnt - snap), 32'd0);
    check("rstmid_idle", 32'(reqReady), 32'd1);
    rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // Silent slave: the access is aborted with an error
    arready = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    wait_resp(400, cyc);
    $display("load timeout -> err=%0b rdata=%h cycles=%0d", resp_err, rdata, cyc);
    check("tmo_err", 32'(resp_err), 32'd1);
    check("tmo_rdata", rdata, 32'h0);
    post("tmo");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
